alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 71 +++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: four requesters share one registered ALU through a round-robin grant;
// each accepted operation runs IDLE -> EXEC -> RESP and is held until the consumer takes it.
module alu_arbiter #(
    parameter int data_width = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              req_valid,
    output logic [3:0]              req_ready,
    input  logic [4*data_width-1:0] req_a,
    input  logic [4*data_width-1:0] req_b,
    input  logic [7:0]              req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_id,
    output logic [data_width-1:0]   rsp_data,
    output logic                    rsp_zero,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state, state_next;
    logic [1:0]            last_grant, grant, op_q, id_q;
    logic [data_width-1:0] a_q, b_q, alu;
    logic                  transfer;

    // Walk the ring from farthest to nearest so the nearest set bit after last_grant wins.
    always_comb begin
        grant = last_grant;
        for (int k = 4; k >= 1; k--)
            if (req_valid[last_grant + 2'(k)]) grant = last_grant + 2'(k);
    end

    assign req_ready = (state == IDLE && !reset && |req_valid) ? 4'b0001 << grant : 4'b0000;
    assign transfer  = |req_ready;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign alu       = op_q[1] ? (op_q[0] ? a_q | b_q : a_q & b_q)
                               : (op_q[0] ? a_q - b_q : a_q + b_q);

    always_comb begin
        state_next = state;
        if (state == IDLE && transfer) state_next = EXEC;
        else if (state == EXEC) state_next = RESP;
        else if (state == RESP && rsp_ready) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= 2'd0;
        end else begin
            state <= state_next;
            if (transfer) begin
                last_grant <= grant;
                a_q        <= req_a[grant*data_width +: data_width];
                b_q        <= req_b[grant*data_width +: data_width];
                op_q       <= req_op[grant*2 +: 2];
                id_q       <= grant;
            end
            if (state == EXEC) begin
                rsp_data <= alu;
                rsp_zero <= alu == '0;
                rsp_id   <= id_q;
            end
        end
    end
endmodule
